// File: rtl/wb_stage.sv
// Writeback stage: selects ALU/MEM/LINK result, extracts and extends sub-word loads,
// registers the write for one cycle, flags misaligned half loads and counts retirements.
module wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] data_mem_i,
    input  logic [DATA_W-1:0] link_i,
    input  logic [1:0]        src_sel_i,
    input  logic [1:0]        ld_size_i,
    input  logic              ld_unsigned_i,
    input  logic              rd_we_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    output logic              wb_we_o,
    output logic [REG_AW-1:0] wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              misalign_o,
    output logic [CNT_W-1:0]  retired_o
);

    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    logic [OFF_W-1:0]  off;
    logic [15:0]       lane;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] result;
    logic              misaligned;
    logic              capture;
    logic              valid_q;
    logic              rd_we_q;
    logic              misaligned_q;

    assign off     = alu_result_i[OFF_W-1:0];
    // Only the low 16 bits after shifting lane OFF down are ever needed.
    assign lane    = 16'(data_mem_i >> {off, 3'b000});
    assign capture = valid_i & ~stall_i & ~flush_i;

    always_comb begin
        load_val = data_mem_i;
        case (ld_size_i)
            2'b00:   load_val = {{(DATA_W-8){~ld_unsigned_i & lane[7]}}, lane[7:0]};
            2'b01:   load_val = {{(DATA_W-16){~ld_unsigned_i & lane[15]}}, lane[15:0]};
            default: load_val = data_mem_i;
        endcase
    end

    always_comb begin
        result = alu_result_i;
        case (src_sel_i)
            2'b01:   result = load_val;
            2'b10:   result = link_i;
            default: result = alu_result_i;
        endcase
    end

    assign misaligned = (src_sel_i == 2'b01) && (ld_size_i == 2'b01) && off[0];

    // The counter advances on the capture edge, so it already includes the
    // instruction currently held in the output register while valid_q is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            rd_we_q      <= 1'b0;
            misaligned_q <= 1'b0;
            wb_addr_o    <= '0;
            wb_data_o    <= '0;
            retired_o    <= '0;
        end else begin
            valid_q <= capture;
            if (capture) begin
                rd_we_q      <= rd_we_i;
                misaligned_q <= misaligned;
                wb_addr_o    <= rd_addr_i;
                wb_data_o    <= result;
                retired_o    <= retired_o + CNT_W'(1);
            end
        end
    end

    assign wb_we_o    = valid_q & rd_we_q & ~misaligned_q & (wb_addr_o != '0);
    assign misalign_o = valid_q & misaligned_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, reset/wrap sequences, and a random run
// against a behavioural model of the writeback rules.
module tb_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, stall_i, flush_i;
    logic [31:0] alu_result_i, data_mem_i, link_i;
    logic [1:0]  src_sel_i, ld_size_i;
    logic        ld_unsigned_i, rd_we_i;
    logic [4:0]  rd_addr_i;
    logic        wb_we_o, misalign_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic [7:0]  retired_o;

    wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i),
        .flush_i(flush_i), .alu_result_i(alu_result_i), .data_mem_i(data_mem_i),
        .link_i(link_i), .src_sel_i(src_sel_i), .ld_size_i(ld_size_i),
        .ld_unsigned_i(ld_unsigned_i), .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i),
        .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .misalign_o(misalign_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic        m_valid, m_we, m_mis, m_known;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_cnt;

    typedef struct {
        logic v, s, f;
        logic [31:0] alu, mem, link;
        logic [1:0] sel, size;
        logic uns, we;
        logic [4:0] rd;
        logic e_we, e_mis;
        logic [4:0] e_addr;
        logic [31:0] e_data;
        logic chk_d;
        logic [7:0] e_ret;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_data();
        int unsigned off = alu_result_i % 4;
        logic [31:0] b = (data_mem_i >> (8 * off)) & 32'hFF;
        logic [31:0] h = (data_mem_i >> (8 * off)) & 32'hFFFF;
        if (src_sel_i == 2'd2) return link_i;
        if (src_sel_i != 2'd1) return alu_result_i;
        if (ld_size_i == 2'd0) return (ld_unsigned_i || b < 128) ? b : b + 32'hFFFF_FF00;
        if (ld_size_i == 2'd1) return (ld_unsigned_i || h < 32768) ? h : h + 32'hFFFF_0000;
        return data_mem_i;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_mis = 0; m_known = 1;
        m_addr = 0; m_data = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        if (valid_i && !stall_i && !flush_i) begin
            m_valid = 1;
            m_we    = rd_we_i;
            m_addr  = rd_addr_i;
            m_data  = model_data();
            m_mis   = (src_sel_i == 2'd1) && (ld_size_i == 2'd1) && (alu_result_i % 2 == 1);
            m_known = !m_mis;
            m_cnt   = (m_cnt + 1) % 256;
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_we"}, 32'(wb_we_o), 32'(m_valid && m_we && !m_mis && m_addr != 0));
        check({tag, "_mis"}, 32'(misalign_o), 32'(m_valid && m_mis));
        check({tag, "_addr"}, 32'(wb_addr_o), 32'(m_addr));
        if (m_known) check({tag, "_data"}, wb_data_o, m_data);
        check({tag, "_ret"}, 32'(retired_o), 32'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = 0; stall_i = 0; flush_i = 0;
        alu_result_i = 0; data_mem_i = 0; link_i = 0;
        src_sel_i = 0; ld_size_i = 0; ld_unsigned_i = 0; rd_we_i = 0; rd_addr_i = 0;
    endtask

    task automatic do_reset();
        rst_i = 1;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 0;
        model_reset();
    endtask

    task automatic drive_vec(input vec_t x);
        valid_i = x.v; stall_i = x.s; flush_i = x.f;
        alu_result_i = x.alu; data_mem_i = x.mem; link_i = x.link;
        src_sel_i = x.sel; ld_size_i = x.size; ld_unsigned_i = x.uns;
        rd_we_i = x.we; rd_addr_i = x.rd;
    endtask

    initial begin
        //          v  s  f  alu           mem           link          sel   size  uns we rd     we mis addr  data          chk ret
        vecs[0]  = '{1, 0, 0, 32'h0000_1234, 32'h0,        32'h0,        2'b00, 2'b00, 0, 1, 5'd5,  1, 0, 5'd5,  32'h0000_1234, 1, 8'd1};
        vecs[1]  = '{1, 0, 0, 32'h0000_0003, 32'h80FF_7F01, 32'h0,        2'b01, 2'b00, 0, 1, 5'd7,  1, 0, 5'd7,  32'hFFFF_FF80, 1, 8'd2};
        vecs[2]  = '{1, 0, 0, 32'h0000_0003, 32'h80FF_7F01, 32'h0,        2'b01, 2'b00, 1, 1, 5'd8,  1, 0, 5'd8,  32'h0000_0080, 1, 8'd3};
        vecs[3]  = '{1, 0, 0, 32'h0000_0001, 32'h1234_5678, 32'h0,        2'b01, 2'b01, 0, 1, 5'd9,  0, 1, 5'd9,  32'h0,         0, 8'd4};
        vecs[4]  = '{1, 0, 0, 32'h0000_AAAA, 32'h0,        32'h0,        2'b00, 2'b00, 0, 1, 5'd0,  0, 0, 5'd0,  32'h0000_AAAA, 1, 8'd5};
        vecs[5]  = '{1, 1, 0, 32'h0000_5555, 32'h0,        32'h0,        2'b00, 2'b00, 0, 1, 5'd3,  0, 0, 5'd0,  32'h0000_AAAA, 1, 8'd5};
        vecs[6]  = '{1, 1, 1, 32'h0000_6666, 32'h0,        32'h0,        2'b00, 2'b00, 0, 1, 5'd3,  0, 0, 5'd0,  32'h0000_AAAA, 1, 8'd5};
        vecs[7]  = '{1, 0, 0, 32'h0000_0000, 32'h0,        32'h0040_0008, 2'b10, 2'b00, 0, 1, 5'd31, 1, 0, 5'd31, 32'h0040_0008, 1, 8'd6};
        vecs[8]  = '{1, 0, 0, 32'h0000_0002, 32'h8001_1234, 32'h0,        2'b01, 2'b01, 0, 1, 5'd4,  1, 0, 5'd4,  32'hFFFF_8001, 1, 8'd7};
        vecs[9]  = '{1, 0, 0, 32'h0000_0001, 32'hDEAD_BEEF, 32'h0,        2'b01, 2'b10, 0, 1, 5'd6,  1, 0, 5'd6,  32'hDEAD_BEEF, 1, 8'd8};
        vecs[10] = '{1, 0, 0, 32'h0000_CAFE, 32'h1111_1111, 32'h2222_2222, 2'b11, 2'b00, 0, 1, 5'd10, 1, 0, 5'd10, 32'h0000_CAFE, 1, 8'd9};
        vecs[11] = '{1, 0, 0, 32'h0000_0001, 32'h80FF_7F01, 32'h0,        2'b01, 2'b00, 0, 1, 5'd11, 1, 0, 5'd11, 32'h0000_007F, 1, 8'd10};
        vecs[12] = '{1, 0, 0, 32'h0000_0001, 32'h0,        32'h0,        2'b00, 2'b00, 0, 0, 5'd12, 0, 0, 5'd12, 32'h0000_0001, 1, 8'd11};
        vecs[13] = '{0, 0, 0, 32'h0000_7777, 32'h0,        32'h0,        2'b00, 2'b00, 0, 1, 5'd13, 0, 0, 5'd12, 32'h0000_0001, 1, 8'd11};

        do_reset();
        check("rst_we", 32'(wb_we_o), 32'd0);
        check("rst_mis", 32'(misalign_o), 32'd0);
        check("rst_addr", 32'(wb_addr_o), 32'd0);
        check("rst_data", wb_data_o, 32'd0);
        check("rst_ret", 32'(retired_o), 32'd0);

        for (int i = 0; i < 14; i++) begin
            drive_vec(vecs[i]);
            step();
            check($sformatf("vec%0d_we", i), 32'(wb_we_o), 32'(vecs[i].e_we));
            check($sformatf("vec%0d_mis", i), 32'(misalign_o), 32'(vecs[i].e_mis));
            check($sformatf("vec%0d_addr", i), 32'(wb_addr_o), 32'(vecs[i].e_addr));
            if (vecs[i].chk_d) check($sformatf("vec%0d_data", i), wb_data_o, vecs[i].e_data);
            check($sformatf("vec%0d_ret", i), 32'(retired_o), 32'(vecs[i].e_ret));
        end
        // Misalign pulse lasts one cycle: vec 4 follows vec 3, already checked mis=0.

        // Counter wrap through all-ones
        do_reset();
        valid_i = 1; rd_we_i = 1; rd_addr_i = 5'd1; alu_result_i = 32'h55;
        repeat (255) step();
        check("wrap_ff", 32'(retired_o), 32'h0000_00FF);
        step();
        check("wrap_zero", 32'(retired_o), 32'd0);
        check_model("wrap");

        // Async reset between edges drops a pending write
        do_reset();
        valid_i = 1; rd_we_i = 1; rd_addr_i = 5'd20; alu_result_i = 32'hABCD_0001;
        step();
        check_model("pend");
        #2 rst_i = 1;
        #1;
        check("arst_we", 32'(wb_we_o), 32'd0);
        check("arst_ret", 32'(retired_o), 32'd0);
        check("arst_addr", 32'(wb_addr_o), 32'd0);
        check("arst_data", wb_data_o, 32'd0);
        #1 rst_i = 0;
        model_reset();
        step();
        check_model("post_rst");
        check("post_rst_we", 32'(wb_we_o), 32'd1);

        // Random run against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            valid_i       = ($urandom % 4) != 0;
            stall_i       = ($urandom % 5) == 0;
            flush_i       = ($urandom % 8) == 0;
            alu_result_i  = $urandom;
            data_mem_i    = $urandom;
            link_i        = $urandom;
            src_sel_i     = 2'($urandom);
            ld_size_i     = 2'($urandom);
            ld_unsigned_i = 1'($urandom);
            rd_we_i       = ($urandom % 4) != 0;
            rd_addr_i     = 5'($urandom);
            step();
            check_model("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
